attitude_angle_sched: RTL and testbench
=======================================

// Module: attitude_angle_sched
// PURPOSE
//  Shares one cordic_angle engine between the pitch and roll computations for each IMU sample.
//  On every accepted accel sample it runs pitch = atan2(ax, sqrt(ay^2+az^2)) first,
//  then roll = atan2(ay, sqrt(ax^2+az^2)).
//  It publishes both angles together as one coherent pair to the attitude filter.
//  It also supervises the engine with a done-watchdog and counts dropped samples.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles in a WAIT state before abort; 0 disables the watchdog
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   async active-low reset
//  s_strobe     in   1   one-cycle pulse: s_ax/s_ay/s_az valid
//  s_ax,s_ay,s_az in 16  signed accel sample
//  eng_start    out  1   start pulse to engine (engine cdra_start)
//  eng_x,eng_y,eng_z out 16 signed operands to engine (engine x,y,z)
//  eng_done     in   1   engine completion pulse (engine cdra_done)
//  eng_angle    in   16  signed engine result (engine crda_angle)
//  pitch,roll   out  16  signed published angles
//  att_valid    out  1   one-cycle pulse: pitch/roll updated
//  busy         out  1   high in every state except IDLE
//  err_timeout  out  1   one-cycle pulse on watchdog abort
//  drop_cnt     out  16  samples dropped while busy, saturating
//  tmo_cnt      out  8   watchdog aborts, saturating
// BEHAVIOUR
//  Reset: all outputs and counters = 0; FSM = IDLE; latched sample and temporaries = 0.
//  FSM: IDLE -> P_GO -> P_WAIT -> R_GO -> R_WAIT -> PUBLISH -> IDLE.
//  IDLE
//   - s_strobe: latch ax/ay/az, go to P_GO.
//   - eng_done: ignored (stale result after an abort).
//  P_GO
//   - eng_start=1 for exactly this cycle.
//   - eng_x=ax, eng_y=ay, eng_z=az.
//   - next state: P_WAIT.
//  P_WAIT
//   - operands held.
//   - on eng_done: pitch_tmp<=eng_angle, go to R_GO.
//  R_GO
//   - eng_start=1 for this cycle only.
//   - eng_x=ay, eng_y=ax, eng_z=az.
//   - next state: R_WAIT.
//  R_WAIT
//   - on eng_done: roll_tmp<=eng_angle, go to PUBLISH.
//  PUBLISH
//   - pitch<=pitch_tmp and roll<=roll_tmp, both registered together.
//   - att_valid=1 for this cycle; next state IDLE.
//  eng_start and eng_x/y/z are registered.
//   - Operands are stable from the GO cycle until the matching eng_done.
//   - Operands are held at their last values in IDLE.
//  R_GO is always at least one cycle after P_WAIT sees eng_done.
//   - This guarantees the engine has left its STOP state before it is restarted.
//  eng_done seen in a GO state: ignored (spurious).
//  Latency: engine done L cycles after its start cycle, strobe at cycle 0:
//   - P_GO at cycle 1.
//   - R_GO at cycle 2+L.
//   - att_valid at cycle 3+2L.
//  Drops
//   - s_strobe while busy=1 (including the PUBLISH cycle): sample discarded.
//   - drop_cnt++, saturating at 16'hFFFF.
//  Watchdog
//   - Cycle counter cleared on entry to each WAIT state; increments each WAIT cycle.
//   - Reaching TIMEOUT_CYC with no eng_done: err_timeout=1 for one cycle, tmo_cnt++ (saturating), FSM -> IDLE.
//   - pitch/roll keep their previous values; no att_valid.
//   - eng_done in the same cycle as the timeout: done wins, no abort.
//  Angles pass through unmodified: same 16-bit signed format as the engine output.
//  rst_n low mid-operation: immediate return to reset state; the in-flight sample is lost.
// TESTING
//  1. Engine model L=20 returns 16'h0400 then 16'hFC00; strobe ax=100, ay=-50, az=4000.
//     -> eng_x/y/z = 100/-50/4000, then -50/100/4000.
//     -> att_valid at cycle 43; pitch=16'h0400, roll=16'hFC00.
//  2. Strobes at cycles 0, 5, 30 with L=20.
//     -> only the sample at cycle 0 is processed; drop_cnt=3? no: =2.
//     -> next strobe after att_valid is accepted.
//  3. TIMEOUT_CYC=10, engine never answers pitch.
//     -> err_timeout pulse 10 cycles after entering P_WAIT; tmo_cnt=1; busy=0; pitch/roll unchanged.
//     -> late eng_done in IDLE is ignored.
//  4. eng_done asserted during P_GO, then real done at L=20.
//     -> pitch_tmp takes the L=20 value only.
//  5. rst_n pulsed low during R_WAIT.
//     -> all outputs 0; no att_valid; a fresh strobe then completes normally.
//  6. 70000 strobes while busy with a stalled engine (TIMEOUT_CYC=0).
//     -> drop_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/attitude_angle_sched.sv
// Runs pitch and then roll through one shared cordic_angle engine for each accepted accel sample.
// Both angles are published together as one pair; the block also runs a done-watchdog and counts dropped samples.
module attitude_angle_sched #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_strobe,
    input  logic signed [15:0] s_ax,
    input  logic signed [15:0] s_ay,
    input  logic signed [15:0] s_az,
    output logic               eng_start,
    output logic signed [15:0] eng_x,
    output logic signed [15:0] eng_y,
    output logic signed [15:0] eng_z,
    input  logic               eng_done,
    input  logic signed [15:0] eng_angle,
    output logic signed [15:0] pitch,
    output logic signed [15:0] roll,
    output logic               att_valid,
    output logic               busy,
    output logic               err_timeout,
    output logic [15:0]        drop_cnt,
    output logic [7:0]         tmo_cnt
);
    localparam int unsigned DW      = 16;
    localparam int unsigned CW      = 16;
    localparam int unsigned TW      = 8;
    localparam int unsigned WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam bit          WD_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_GO,
        S_P_WAIT,
        S_R_GO,
        S_R_WAIT,
        S_PUBLISH
    } state_t;

    typedef struct packed {
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] y;
        logic signed [DW-1:0] z;
    } vec_t;

    state_t               state;
    vec_t                 sample;
    logic signed [DW-1:0] pitch_tmp;
    logic [WD_W-1:0]      wd_cnt;
    logic                 wd_expire_c;
    logic                 drop_c;

    // Wait-state cycles run 0..TIMEOUT_CYC-1; the last of them without a done aborts.
    assign wd_expire_c = WD_EN && (wd_cnt == WD_W'(WD_LAST));
    assign drop_c      = s_strobe && (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sample      <= '0;
            pitch_tmp   <= '0;
            wd_cnt      <= '0;
            eng_start   <= 1'b0;
            eng_x       <= '0;
            eng_y       <= '0;
            eng_z       <= '0;
            pitch       <= '0;
            roll        <= '0;
            att_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            eng_start   <= 1'b0;
            att_valid   <= 1'b0;
            err_timeout <= 1'b0;

            if (drop_c && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CW'(1);
            end

            unique case (state)
                S_IDLE: begin
                    // eng_done here is a stale result from an aborted run and is ignored
                    if (s_strobe) begin
                        sample    <= '{x: s_ax, y: s_ay, z: s_az};
                        eng_x     <= s_ax;
                        eng_y     <= s_ay;
                        eng_z     <= s_az;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_P_GO;
                    end
                end

                S_P_GO: begin
                    wd_cnt <= '0;
                    state  <= S_P_WAIT;
                end

                S_P_WAIT: begin
                    if (eng_done) begin
                        pitch_tmp <= eng_angle;
                        eng_x     <= sample.y;
                        eng_y     <= sample.x;
                        eng_z     <= sample.z;
                        eng_start <= 1'b1;
                        state     <= S_R_GO;
                    end else if (wd_expire_c) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                        if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                S_R_GO: begin
                    wd_cnt <= '0;
                    state  <= S_R_WAIT;
                end

                S_R_WAIT: begin
                    // Both angles update on the same edge so the filter never sees a torn pair.
                    if (eng_done) begin
                        pitch     <= pitch_tmp;
                        roll      <= eng_angle;
                        att_valid <= 1'b1;
                        state     <= S_PUBLISH;
                    end else if (wd_expire_c) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                        if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                S_PUBLISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attitude_angle_sched.sv
// Scoreboard bench for attitude_angle_sched: a behavioural engine model, a timing/acceptance reference model,
// and three instances covering the default watchdog, a short watchdog and a disabled watchdog.
module tb_attitude_angle_sched;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               rst_n;
    logic               s_strobe;
    logic signed [15:0] s_ax, s_ay, s_az;
    logic               eng_done;
    logic signed [15:0] eng_angle;
    int                 sel;

    logic [NI-1:0]      strb_i, done_i;
    logic [NI-1:0]      start_o, av_o, busy_o, err_o;
    logic signed [15:0] ex_o [NI];
    logic signed [15:0] ey_o [NI];
    logic signed [15:0] ez_o [NI];
    logic signed [15:0] pitch_o [NI];
    logic signed [15:0] roll_o [NI];
    logic [15:0]        drop_o [NI];
    logic [7:0]         tmo_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign strb_i[g] = s_strobe && (sel == g);
        assign done_i[g] = eng_done && (sel == g);
        attitude_angle_sched #(.TIMEOUT_CYC(g == 0 ? 255 : (g == 1 ? 10 : 0))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .s_strobe   (strb_i[g]),
            .s_ax       (s_ax),
            .s_ay       (s_ay),
            .s_az       (s_az),
            .eng_start  (start_o[g]),
            .eng_x      (ex_o[g]),
            .eng_y      (ey_o[g]),
            .eng_z      (ez_o[g]),
            .eng_done   (done_i[g]),
            .eng_angle  (eng_angle),
            .pitch      (pitch_o[g]),
            .roll       (roll_o[g]),
            .att_valid  (av_o[g]),
            .busy       (busy_o[g]),
            .err_timeout(err_o[g]),
            .drop_cnt   (drop_o[g]),
            .tmo_cnt    (tmo_o[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the engine's result: any fixed function of its operands works.
    function automatic logic [15:0] fangle(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        int v;
        v = 3 * int'($signed(x)) + 7 * int'($signed(y)) - int'($signed(z));
        return 16'(v) ^ 16'h5A5A;
    endfunction

    function automatic logic [47:0] pack3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return {a, b, c};
    endfunction

    function automatic logic [47:0] ops(input int i);
        return {ex_o[i], ey_o[i], ez_o[i]};
    endfunction

    function automatic logic [127:0] outs(input int i);
        return {start_o[i], av_o[i], busy_o[i], err_o[i], ex_o[i], ey_o[i], ez_o[i],
                pitch_o[i], roll_o[i], drop_o[i], tmo_o[i]};
    endfunction

    // Engine model: answers L cycles after its start cycle and computes from the operands it sees at done time.
    int          eng_lat = 20;
    bit          eng_mute = 1'b0;
    int          spur_cyc = -1;
    logic [15:0] fixed_q[$];

    initial begin
        int due;
        bit armed;
        armed = 1'b0;
        due = 0;
        eng_done = 1'b0;
        eng_angle = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (!rst_n) begin
                armed = 1'b0;
            end else begin
                if (start_o[sel]) begin
                    armed = 1'b1;
                    due = cyc + eng_lat;
                end
                if (cyc == spur_cyc) begin
                    eng_done = 1'b1;
                    eng_angle = 16'hDEAD;
                end else if (armed && !eng_mute && cyc == due) begin
                    eng_done = 1'b1;
                    armed = 1'b0;
                    if (fixed_q.size() > 0) eng_angle = fixed_q.pop_front();
                    else eng_angle = fangle(ex_o[sel], ey_o[sel], ez_o[sel]);
                end
            end
        end
    end

    // Reference model for instance 0: one sample in flight, publication at strobe+3+2L.
    typedef struct {
        logic [15:0] p;
        logic [15:0] r;
        int          c;
    } exp_t;

    exp_t sb_q[$];
    int   busy_until = -1;
    int   exp_drops = 0;

    task automatic model_strobe(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az);
        exp_t e;
        if (cyc > busy_until) begin
            busy_until = cyc + 3 + 2 * eng_lat;
            e.p = fangle(ax, ay, az);
            e.r = fangle(ay, ax, az);
            e.c = busy_until;
            sb_q.push_back(e);
        end else begin
            exp_drops++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && av_o[0]) begin
            if (sb_q.size() == 0) begin
                check("unexpected_att_valid", av_o[0], 0);
            end else begin
                e = sb_q.pop_front();
                check("pitch", $unsigned(pitch_o[0]), e.p);
                check("roll", $unsigned(roll_o[0]), e.r);
                check("publish_cycle", cyc, e.c);
            end
        end
    end

    int av_cnt [NI] = '{default: 0};
    int err_cnt [NI] = '{default: 0};
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (av_o[i]) av_cnt[i]++;
            if (err_o[i]) err_cnt[i]++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle strobe in the current cycle; returns one cycle later.
    task automatic pulse(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az);
        s_ax = ax;
        s_ay = ay;
        s_az = az;
        s_strobe = 1'b1;
        if (sel == 0) model_strobe(ax, ay, az);
        step(1);
        s_strobe = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o[sel] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_within_budget_u%0d", sel), busy_o[sel], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb_q.delete();
        busy_until = -1;
        exp_drops = 0;
    endtask

    initial begin
        int          c, t_err, n_err, av_before;
        logic [15:0] a, b, z, exp_p, exp_r;

        sel = 0;
        s_strobe = 1'b0;
        s_ax = '0;
        s_ay = '0;
        s_az = '0;
        apply_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check($sformatf("reset_outputs_u%0d", i), outs(i), 0);
        rst_n = 1'b1;
        step(2);

        // Fixed engine results, operand order for both phases, publish at strobe+43.
        eng_lat = 20;
        fixed_q.push_back(16'h0400);
        fixed_q.push_back(16'hFC00);
        c = cyc;
        pulse(16'd100, 16'(-50), 16'd4000);
        sb_q[0].p = 16'h0400;
        sb_q[0].r = 16'hFC00;
        check("t1_publish_at_43", sb_q[0].c - c, 43);
        @(negedge clk);
        check("t1_p_go_start", start_o[0], 1);
        check("t1_p_go_ops", ops(0), pack3(16'd100, 16'(-50), 16'd4000));
        step(10);
        @(negedge clk);
        check("t1_p_wait_start", start_o[0], 0);
        check("t1_p_wait_ops_held", ops(0), pack3(16'd100, 16'(-50), 16'd4000));
        step(11);
        @(negedge clk);
        check("t1_r_go_start", start_o[0], 1);
        check("t1_r_go_ops", ops(0), pack3(16'(-50), 16'd100, 16'd4000));
        step(1);
        wait_idle(100);

        // Strobes at +0, +5, +30 while busy; then one in the PUBLISH cycle and one right after.
        c = cyc;
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        step(4);
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        step(24);
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        @(negedge clk);
        check("t2_drop_cnt_after_busy_strobes", drop_o[0], 16'd2);
        step(12);
        check("t2_at_publish_cycle", cyc - c, 43);
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        wait_idle(200);
        check("t2_drop_cnt_total", drop_o[0], 16'(exp_drops));

        // Spurious done in P_GO must be ignored; operands at the signed extremes.
        spur_cyc = cyc + 1;
        pulse(16'h8000, 16'h7FFF, 16'h8000);
        wait_idle(100);

        // Async reset while in R_WAIT, then a fresh sample completes normally.
        c = cyc;
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        step(29);
        apply_reset();
        @(negedge clk);
        check("t5_outputs_in_reset", outs(0), 0);
        step(2);
        rst_n = 1'b1;
        step(30);
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        wait_idle(100);

        // Random strobes against the reference model, with a fresh engine latency per segment.
        for (int seg = 0; seg < 3; seg++) begin
            eng_lat = int'($urandom_range(1, 25));
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(0, 5) == 0) pulse(16'($urandom), 16'($urandom), 16'($urandom));
                else step(1);
            end
            wait_idle(200);
            check($sformatf("rand_drop_cnt_seg%0d", seg), drop_o[0], 16'(exp_drops));
        end
        check("main_no_timeouts", err_cnt[0], 0);
        check("scoreboard_drained", sb_q.size(), 0);

        // TIMEOUT_CYC=10: a normal run, then done exactly in the last wait cycle (done wins).
        sel = 1;
        eng_lat = 3;
        a = 16'($urandom);
        b = 16'($urandom);
        z = 16'($urandom);
        pulse(a, b, z);
        wait_idle(100);
        check("wd_short_run_pitch", $unsigned(pitch_o[1]), fangle(a, b, z));
        eng_lat = 10;
        a = 16'($urandom);
        b = 16'($urandom);
        z = 16'($urandom);
        exp_p = fangle(a, b, z);
        exp_r = fangle(b, a, z);
        pulse(a, b, z);
        wait_idle(100);
        check("wd_boundary_done_wins_err", err_cnt[1], 0);
        check("wd_boundary_att_valid", av_cnt[1], 2);
        check("wd_boundary_pitch", $unsigned(pitch_o[1]), exp_p);
        check("wd_boundary_roll", $unsigned(roll_o[1]), exp_r);

        // Engine never answers: abort 10 cycles after entering P_WAIT, angles untouched.
        eng_mute = 1'b1;
        av_before = av_cnt[1];
        c = cyc;
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        t_err = -1;
        n_err = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (err_o[1]) begin
                n_err++;
                if (t_err < 0) t_err = cyc;
            end
            @(posedge clk);
            #1;
        end
        check("wd_err_cycle", t_err - c, 12);
        check("wd_err_pulse_width", n_err, 1);
        check("wd_tmo_cnt", tmo_o[1], 8'd1);
        check("wd_busy_after_abort", busy_o[1], 0);
        check("wd_pitch_kept", $unsigned(pitch_o[1]), exp_p);
        check("wd_roll_kept", $unsigned(roll_o[1]), exp_r);
        spur_cyc = cyc + 2;
        step(6);
        check("wd_late_done_ignored_busy", busy_o[1], 0);
        check("wd_late_done_no_valid", av_cnt[1], av_before);

        // One cycle too late: L=11 aborts and its done then lands in IDLE.
        eng_mute = 1'b0;
        eng_lat = 11;
        pulse(16'($urandom), 16'($urandom), 16'($urandom));
        wait_idle(100);
        step(5);
        check("wd_l11_tmo_cnt", tmo_o[1], 8'd2);
        check("wd_l11_no_valid", av_cnt[1], av_before);
        check("wd_l11_busy", busy_o[1], 0);

        // Watchdog disabled, stalled engine, strobe held high: drop counter saturates.
        sel = 2;
        eng_mute = 1'b1;
        s_ax = 16'($urandom);
        s_ay = 16'($urandom);
        s_az = 16'($urandom);
        s_strobe = 1'b1;
        step(1000);
        @(negedge clk);
        check("sat_drop_cnt_partial", drop_o[2], 16'd999);
        step(69000);
        s_strobe = 1'b0;
        @(negedge clk);
        check("sat_drop_cnt", drop_o[2], 16'hFFFF);
        check("sat_still_busy", busy_o[2], 1);
        check("sat_no_timeout", tmo_o[2], 8'd0);
        check("sat_no_valid", av_cnt[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
